rgb_timing_monitor: RTL and testbench
=====================================

# rgb_timing_monitor

Passive monitor on the RGB bus between the LCD timing driver and the SSD2828 bridge. It samples `hs`/`vs`/`den`/`rgb` on the pixel clock and measures the geometry of every frame: active width, active height, line total and frame total. It compares each frame against expected values, raises sticky error flags and counts frames. It never drives the bus; it is used for bring-up, and its outputs go to LEDs or a debug readout.

## Interface
- `EXP_H_ACTIVE`, default 750: expected `den`-high pixels per active line.
- `EXP_V_ACTIVE`, default 1334: expected active lines per frame.
- `SYNC_ACTIVE_LOW`, default 1: 1 means `hs`/`vs` are asserted low; 0 means asserted high.
- `pclk` in, 1: pixel clock, the same net that drives the timing driver.
- `rst_n` in, 1: asynchronous active-low reset.
- `hs` in, 1: horizontal sync.
- `vs` in, 1: vertical sync.
- `den` in, 1: data enable.
- `rgb` in, 24: pixel data. Used only when `RGB_MON_SUM_EN` is defined.
- `clr_err` in, 1: synchronous clear of the sticky error flags.
- `meas_h_active` out, 12: `den` run length of the last active line of the last frame.
- `meas_v_active` out, 12: active-line count of the last frame.
- `meas_h_total` out, 12: `pclk` cycles between the last two `hs` assertions.
- `meas_v_total` out, 12: `hs` assertions in the last frame.
- `frame_cnt` out, 16: completed frames, wrapping.
- `meas_valid` out, 1: high once at least one complete frame has been measured.
- `frame_tick` out, 1: one-cycle pulse when the measurement registers update.
- `err_geom` out, 1: sticky flag; a frame mismatched `EXP_H_ACTIVE` or `EXP_V_ACTIVE`.
- `err_den_gap` out, 1: sticky flag; `den` rose more than once within one line.
- `frame_sum` out, 32: present only with `RGB_MON_SUM_EN`.

## Operation
- **Input stage:** `hs`, `vs`, `den` and `rgb` are registered once into stage-1 registers, then once more to form a one-cycle-delayed copy for edge detection. Sync polarity is normalised with `SYNC_ACTIVE_LOW`.
- **Edges:**
  - Line start is the asserting edge of `hs`.
  - Frame start is the asserting edge of `vs`.
- **Per-line counters:**
  - `h_cnt` counts `pclk` cycles since line start.
  - `den_cnt` counts `den`-high cycles in the line.
  - `den_rises` counts rising edges of `den` in the line.
  - All three reset to 0 at line start, after their values are captured.
- **At line start:**
  - `h_cnt` is latched to `meas_h_total`.
  - If `den_cnt` is nonzero, the line is active: `line_act` increments and `den_cnt` is latched to a holding register `last_h_act`.
  - If `den_rises` is greater than 1, `err_den_gap` is set.
- **Per-frame counters:**
  - `line_tot` increments on every line start.
  - `line_act` increments as described above.
  - Both reset to 0 at frame start, after capture.
- **State machine:**
  - States: `WAIT_VS`, `FIRST`, `RUN`.
  - Reset enters `WAIT_VS`.
  - The first frame-start edge moves `WAIT_VS` to `FIRST`. Nothing is latched on this transition, so the partial frame is discarded.
  - The next frame-start edge moves `FIRST` to `RUN` and performs a capture.
  - Every later frame-start edge in `RUN` performs a capture.
- **Capture:**
  - `last_h_act` is latched to `meas_h_active`, `line_act` to `meas_v_active`, and `line_tot` to `meas_v_total`.
  - `frame_cnt` increments.
  - `meas_valid` is set to 1.
  - `frame_tick` pulses.
  - If `last_h_act` is not equal to `EXP_H_ACTIVE`, or `line_act` is not equal to `EXP_V_ACTIVE`, `err_geom` is set.
- **Arithmetic:**
  - All 12-bit counters saturate at 4095; they do not wrap.
  - `frame_cnt` wraps from 65535 to 0.
- **Simultaneous events:**
  - A frame-start edge and a line-start edge in the same cycle are both processed. Line capture happens first, so that line counts in the frame being closed.
  - `clr_err` has priority over setting a flag in the same cycle. The flag clears, and an error occurring in that same cycle is lost.

## Timing
- **Reset values:** all outputs are 0 and the state is `WAIT_VS`.
- **Update latency:** measurement outputs and `frame_tick` update on the 3rd `pclk` rising edge after the sync edge appears on the input pins: 1 cycle for the input register, 1 cycle for edge detection, 1 cycle for capture.
- **Flag latency:** `err_*` flags rise in the same cycle as the corresponding capture.
- **Clear:** `clr_err` is sampled on `pclk`; the flags read 0 on the next cycle.
- **Reset mid-frame:** all registers return to reset values and the state returns to `WAIT_VS`. The next partial frame is discarded.
- **Missing `vs` (frozen source):** outputs hold their last values, and `line_tot` saturates.

## Configuration
- `RGB_MON_SUM_EN` defined:
  - A 32-bit wrapping accumulator adds `{8'h00, rgb}` on every `den`-high cycle.
  - It is latched to `frame_sum` at capture and cleared at frame start.
- `RGB_MON_SUM_EN` undefined:
  - The accumulator and the `frame_sum` port are absent.
  - `rgb` is unused.
  - All other behaviour is identical.

## Test plan
- **Nominal geometry:** 750×1334 active, 800 line total, 1350 frame total, 3 frames -> after the 2nd `vs`: `meas_h_active`=750, `meas_v_active`=1334, `meas_h_total`=800, `meas_v_total`=1350, `meas_valid`=1, `frame_cnt`=1, `err_geom`=0.
- **Short frame:** one frame with 1333 active lines -> `err_geom`=1 at that capture. The flag stays 1 until `clr_err`, then reads 0.
- **Gap in `den`:** `den` split into 400 + 350 within one line -> `err_den_gap`=1, `meas_h_active`=750.
- **Reset mid-frame:** assert `rst_n`=0 mid-frame, then release -> all outputs 0. The first capture occurs at the 2nd `vs` after release.
- **Saturation and polarity:** `SYNC_ACTIVE_LOW`=0 with a line of 5000 cycles -> `meas_h_total`=4095.
- **Pixel sum (`RGB_MON_SUM_EN`):** a constant `rgb`=24'h000001 over a 750×1334 frame -> `frame_sum`=1,000,500.

Source files
------------

// File: rtl/rgb_timing_monitor.sv
// rgb_timing_monitor
// ------------------
// Passive bring-up monitor on the RGB bus between the LCD timing driver and
// the SSD2828 bridge. It measures the geometry of every frame, checks it
// against the expected active size, and raises sticky error flags. It never
// drives the bus.
//
// Optional feature macro: RGB_MON_SUM_EN adds a per-frame pixel sum
// accumulator and the frame_sum output.
//
// Parameters:
//   EXP_H_ACTIVE     expected den-high pixels per active line
//   EXP_V_ACTIVE     expected active lines per frame
//   SYNC_ACTIVE_LOW  1: hs/vs asserted low, 0: asserted high
//
// Ports:
//   pclk, rst_n      pixel clock, asynchronous active-low reset
//   hs, vs, den, rgb monitored bus (rgb used only with RGB_MON_SUM_EN)
//   clr_err          synchronous clear of the sticky error flags
//   meas_h_active    den run length of the last active line of the last frame
//   meas_v_active    active-line count of the last frame
//   meas_h_total     pclk cycles between the last two hs assertions
//   meas_v_total     hs assertions in the last frame
//   frame_cnt        completed frames (wrapping)
//   meas_valid       set once a complete frame has been measured
//   frame_tick       one-cycle pulse when the frame measurements update
//   err_geom         sticky: a frame mismatched the expected active size
//   err_den_gap      sticky: den rose more than once within one line
//   frame_sum        per-frame sum of {8'h00, rgb} over den-high cycles
//                    (RGB_MON_SUM_EN only)
//
// Valid/ready: none. The block is a pure observer; frame_tick is a
// qualifier pulse with no back-pressure.
module rgb_timing_monitor #(
  parameter int EXP_H_ACTIVE    = 750,
  parameter int EXP_V_ACTIVE    = 1334,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        den,
  input  logic [23:0] rgb,
  input  logic        clr_err,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_active,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_v_total,
  output logic [15:0] frame_cnt,
  output logic        meas_valid,
  output logic        frame_tick,
  output logic        err_geom,
  output logic        err_den_gap
`ifdef RGB_MON_SUM_EN
  ,
  output logic [31:0] frame_sum
`endif
);

  localparam logic [11:0] EXP_H = 12'(EXP_H_ACTIVE);
  localparam logic [11:0] EXP_V = 12'(EXP_V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    FIRST   = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t state, state_nxt;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Syncs normalised to active-high before the first register.
  logic hs_n, vs_n;
  assign hs_n = SYNC_ACTIVE_LOW ? ~hs : hs;
  assign vs_n = SYNC_ACTIVE_LOW ? ~vs : vs;

  logic hs_s1, vs_s1, den_s1;
  logic hs_s2, vs_s2, den_s2;
  // Registered edge pulses; they line up in time with den_s2.
  logic line_start, frame_start, den_rise;

  logic [11:0] h_cnt, den_cnt, last_h_act, line_act, line_tot;
  logic [1:0]  den_rises;

  logic [11:0] line_act_upd, last_h_act_upd, line_tot_upd;
  logic        line_is_act, capture, geom_bad, gap_bad;

  // Line capture is folded into these values first, so a line start that
  // coincides with a frame start still counts in the frame being closed.
  always_comb begin
    line_is_act    = line_start && (den_cnt != 12'd0);
    line_act_upd   = line_is_act ? sat_inc(line_act) : line_act;
    last_h_act_upd = line_is_act ? den_cnt : last_h_act;
    line_tot_upd   = line_start ? sat_inc(line_tot) : line_tot;
    capture        = frame_start && (state != WAIT_VS);
    geom_bad       = (last_h_act_upd != EXP_H) || (line_act_upd != EXP_V);
    gap_bad        = line_start && (den_rises > 2'd1);
  end

  // The first frame start after reset only arms the monitor: the partial
  // frame before it is discarded.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VS: if (frame_start) state_nxt = FIRST;
      FIRST:   if (frame_start) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = WAIT_VS;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_VS;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
      den_s1      <= 1'b0;
      hs_s2       <= 1'b0;
      vs_s2       <= 1'b0;
      den_s2      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      den_rise    <= 1'b0;
    end else begin
      hs_s1       <= hs_n;
      vs_s1       <= vs_n;
      den_s1      <= den;
      hs_s2       <= hs_s1;
      vs_s2       <= vs_s1;
      den_s2      <= den_s1;
      line_start  <= hs_s1 & ~hs_s2;
      frame_start <= vs_s1 & ~vs_s2;
      den_rise    <= den_s1 & ~den_s2;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt         <= 12'd0;
      den_cnt       <= 12'd0;
      den_rises     <= 2'd0;
      last_h_act    <= 12'd0;
      line_act      <= 12'd0;
      line_tot      <= 12'd0;
      meas_h_active <= 12'd0;
      meas_v_active <= 12'd0;
      meas_h_total  <= 12'd0;
      meas_v_total  <= 12'd0;
      frame_cnt     <= 16'd0;
      meas_valid    <= 1'b0;
      frame_tick    <= 1'b0;
      err_geom      <= 1'b0;
      err_den_gap   <= 1'b0;
    end else begin
      // The line-start cycle itself is the first cycle of the new line, so
      // the counters restart at that cycle's contribution, not at zero.
      if (line_start) begin
        meas_h_total <= h_cnt;
        h_cnt        <= 12'd1;
        den_cnt      <= {11'd0, den_s2};
        den_rises    <= {1'b0, den_rise};
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (den_s2) den_cnt <= sat_inc(den_cnt);
        if (den_rise && (den_rises != 2'd3)) den_rises <= den_rises + 2'd1;
      end

      last_h_act <= last_h_act_upd;
      line_act   <= frame_start ? 12'd0 : line_act_upd;
      line_tot   <= frame_start ? 12'd0 : line_tot_upd;

      frame_tick <= capture;
      if (capture) begin
        meas_h_active <= last_h_act_upd;
        meas_v_active <= line_act_upd;
        meas_v_total  <= line_tot_upd;
        frame_cnt     <= frame_cnt + 16'd1;
        meas_valid    <= 1'b1;
      end

      // Clear wins over a same-cycle error, which is then lost.
      if (clr_err)                    err_geom <= 1'b0;
      else if (capture && geom_bad)   err_geom <= 1'b1;

      if (clr_err)                    err_den_gap <= 1'b0;
      else if (gap_bad)               err_den_gap <= 1'b1;
    end
  end

`ifdef RGB_MON_SUM_EN
  logic [23:0] rgb_s1, rgb_s2;
  logic [31:0] pix_acc;

  // The frame-start cycle belongs to the new frame, so the closing sum is
  // the accumulator value before this cycle's pixel.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1    <= 24'd0;
      rgb_s2    <= 24'd0;
      pix_acc   <= 32'd0;
      frame_sum <= 32'd0;
    end else begin
      rgb_s1 <= rgb;
      rgb_s2 <= rgb_s1;
      if (frame_start) pix_acc <= den_s2 ? {8'h00, rgb_s2} : 32'd0;
      else if (den_s2) pix_acc <= pix_acc + {8'h00, rgb_s2};
      if (capture) frame_sum <= pix_acc;
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
`endif

endmodule

// File: tb/tb_rgb_timing_monitor.sv
// Testbench for rgb_timing_monitor. Uses a reduced frame geometry
// (20x6 active, 32 line total, 10 frame total) so several frames fit in a
// short run; a second instance with active-high syncs covers polarity and
// 12-bit saturation. Build with RGB_MON_SUM_EN defined to also check
// frame_sum.
module tb_rgb_timing_monitor;

  localparam int H_ACT = 20;
  localparam int V_ACT = 6;
  localparam int LT    = 32;

  logic        pclk;
  logic        rst_n;
  logic        hs, vs, den, clr_err;
  logic        hs_h, vs_h, den_h;
  logic [23:0] rgb;

  logic [11:0] meas_h_active, meas_v_active, meas_h_total, meas_v_total;
  logic [15:0] frame_cnt;
  logic        meas_valid, frame_tick, err_geom, err_den_gap;

  logic [11:0] meas_h_active_h, meas_v_active_h, meas_h_total_h, meas_v_total_h;
  logic [15:0] frame_cnt_h;
  logic        meas_valid_h, frame_tick_h, err_geom_h, err_den_gap_h;

`ifdef RGB_MON_SUM_EN
  logic [31:0] frame_sum, frame_sum_h;
  logic [31:0] sum_q[$];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // {err_geom, h_act, v_act, h_tot, v_tot, frame_cnt}
  logic [64:0] exp_q[$];
  logic [64:0] e;
  logic [15:0] exp_frames;
  logic        err_model;

  rgb_timing_monitor #(
    .EXP_H_ACTIVE(H_ACT), .EXP_V_ACTIVE(V_ACT), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .hs(hs), .vs(vs), .den(den), .rgb(rgb),
    .clr_err(clr_err),
    .meas_h_active(meas_h_active), .meas_v_active(meas_v_active),
    .meas_h_total(meas_h_total), .meas_v_total(meas_v_total),
    .frame_cnt(frame_cnt), .meas_valid(meas_valid), .frame_tick(frame_tick),
    .err_geom(err_geom), .err_den_gap(err_den_gap)
`ifdef RGB_MON_SUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  rgb_timing_monitor #(
    .EXP_H_ACTIVE(H_ACT), .EXP_V_ACTIVE(V_ACT), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .pclk(pclk), .rst_n(rst_n), .hs(hs_h), .vs(vs_h), .den(den_h), .rgb(rgb),
    .clr_err(clr_err),
    .meas_h_active(meas_h_active_h), .meas_v_active(meas_v_active_h),
    .meas_h_total(meas_h_total_h), .meas_v_total(meas_v_total_h),
    .frame_cnt(frame_cnt_h), .meas_valid(meas_valid_h), .frame_tick(frame_tick_h),
    .err_geom(err_geom_h), .err_den_gap(err_den_gap_h)
`ifdef RGB_MON_SUM_EN
    , .frame_sum(frame_sum_h)
`endif
  );

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_zero(input string who);
    check({who, "_h_active"}, 32'(meas_h_active), 32'd0);
    check({who, "_v_active"}, 32'(meas_v_active), 32'd0);
    check({who, "_h_total"},  32'(meas_h_total),  32'd0);
    check({who, "_v_total"},  32'(meas_v_total),  32'd0);
    check({who, "_frame_cnt"}, 32'(frame_cnt),    32'd0);
    check({who, "_valid"},    32'(meas_valid),    32'd0);
    check({who, "_tick"},     32'(frame_tick),    32'd0);
    check({who, "_err_geom"}, 32'(err_geom),      32'd0);
    check({who, "_err_gap"},  32'(err_den_gap),   32'd0);
  endtask

  // Driver: one frame starting with a vs+hs assertion at line 0 cycle 0.
  // Active lines are 2 .. 2+n_act-1, den at cycles 6..25; a gap line splits
  // den into 12 + 8 pixels. clr_line pulses clr_err mid-line.
  task automatic drive_frame(input int n_lines, input int n_act, input int gap_line,
                             input int clr_line, input bit do_push, input bit chk_lat);
    logic err_prev;
    bit   act;
`ifdef RGB_MON_SUM_EN
    logic [31:0] exp_sum = 32'd0;
`endif
    err_prev = err_model;
    if (do_push) begin
      if (clr_line >= 0) err_model = (n_act != V_ACT);
      else               err_model = err_model | (n_act != V_ACT);
      exp_frames = exp_frames + 16'd1;
      exp_q.push_back({err_model, 12'(H_ACT), 12'(n_act), 12'(LT), 12'(n_lines), exp_frames});
    end
    for (int l = 0; l < n_lines; l++) begin
      for (int c = 0; c < LT; c++) begin
        if (chk_lat && l == 0 && c == 2) check("tick_early", 32'(frame_tick), 32'd0);
        if (chk_lat && l == 0 && c == 3) check("tick_latency", 32'(frame_tick), 32'd1);
        if (l == clr_line && c == 10) check("err_geom_sticky", 32'(err_geom), 32'(err_prev));
        if (l == clr_line && c == 11) check("err_geom_cleared", 32'(err_geom), 32'd0);
        clr_err = (l == clr_line && c == 10);
        hs  = (c < 3) ? 1'b0 : 1'b1;
        vs  = (l < 2) ? 1'b0 : 1'b1;
        act = (l >= 2) && (l < 2 + n_act);
        if (l == gap_line) den = ((c >= 6 && c < 18) || (c >= 20 && c < 28));
        else               den = act && (c >= 6) && (c < 6 + H_ACT);
        rgb = 24'($urandom_range(0, 32'h00FF_FFFF));
`ifdef RGB_MON_SUM_EN
        if (den) exp_sum = exp_sum + {8'h00, rgb};
`endif
        step();
      end
    end
    clr_err = 1'b0;
`ifdef RGB_MON_SUM_EN
    if (do_push) sum_q.push_back(exp_sum);
`endif
  endtask

  task automatic line_hi(input int total, input int width);
    for (int c = 0; c < total; c++) begin
      hs_h = (c < width);
      step();
    end
  endtask

  // Scoreboard: pop one expected frame per frame_tick.
  always @(negedge pclk) begin
    if (rst_n && frame_tick) begin
      check("tick_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_err_geom", 32'(e[64]),    32'(err_geom));
        check("sb_h_active", 32'(meas_h_active), 32'(e[63:52]));
        check("sb_v_active", 32'(meas_v_active), 32'(e[51:40]));
        check("sb_h_total",  32'(meas_h_total),  32'(e[39:28]));
        check("sb_v_total",  32'(meas_v_total),  32'(e[27:16]));
        check("sb_frame_cnt", 32'(frame_cnt),    32'(e[15:0]));
        check("sb_valid",    32'(meas_valid),    32'd1);
      end
`ifdef RGB_MON_SUM_EN
      if (sum_q.size() != 0) check("sb_frame_sum", frame_sum, sum_q.pop_front());
`endif
    end
  end

  initial begin
    rst_n = 1'b0; clr_err = 1'b0;
    hs = 1'b1; vs = 1'b1; den = 1'b0; rgb = 24'd0;
    hs_h = 1'b0; vs_h = 1'b0; den_h = 1'b0;
    exp_frames = 16'd0; err_model = 1'b0;
    repeat (3) step();
    check_zero("reset");
    check("reset_hi_h_total", 32'(meas_h_total_h), 32'd0);
    rst_n = 1'b1;
    repeat (5) step();

    // Nominal frames; the first vs only arms the monitor.
    drive_frame(10, V_ACT, -1, -1, 1'b1, 1'b0);
    check("armed_no_valid", 32'(meas_valid), 32'd0);
    check("armed_frame_cnt", 32'(frame_cnt), 32'd0);
    drive_frame(10, V_ACT, -1, -1, 1'b1, 1'b1);
    check("first_valid", 32'(meas_valid), 32'd1);
    check("first_frame_cnt", 32'(frame_cnt), 32'd1);
    check("first_err_geom", 32'(err_geom), 32'd0);

    // Short frame, then a frame that clears the flag mid-way.
    drive_frame(10, V_ACT - 1, -1, -1, 1'b1, 1'b1);
    drive_frame(10, V_ACT, -1, 2, 1'b1, 1'b1);
    check("gap_before", 32'(err_den_gap), 32'd0);

    // den split 12 + 8 on the last active line.
    drive_frame(10, V_ACT, 7, -1, 1'b1, 1'b1);
    check("gap_set", 32'(err_den_gap), 32'd1);
    drive_frame(10, V_ACT, -1, -1, 1'b1, 1'b1);

    // Partial frame, then reset in the middle of it.
    drive_frame(4, 2, -1, -1, 1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (2) step();
    check_zero("midreset");
    check("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
    exp_frames = 16'd0; err_model = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();

    drive_frame(10, V_ACT, -1, -1, 1'b1, 1'b0);
    check("rearm_no_valid", 32'(meas_valid), 32'd0);
    check("rearm_frame_cnt", 32'(frame_cnt), 32'd0);
    drive_frame(10, V_ACT, -1, -1, 1'b1, 1'b1);
    check("rearm_frame_cnt_1", 32'(frame_cnt), 32'd1);
    drive_frame(3, 0, -1, -1, 1'b0, 1'b1);
    repeat (8) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Active-high syncs: rises 40 apart with varying pulse width, so only
    // the asserting edge gives 40.
    line_hi(40, 4);
    line_hi(40, 10);
    line_hi(40, 4);
    check("hi_h_total", 32'(meas_h_total_h), 32'd40);
    check("hi_no_valid", 32'(meas_valid_h), 32'd0);
    line_hi(5000, 4);
    line_hi(40, 4);
    check("hi_h_total_sat", 32'(meas_h_total_h), 32'd4095);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
